data_mem_arbiter: RTL and testbench

- Shares one single-port synchronous data memory between NUM_CORES processor cores in the multicore build.
- Sits between each core's data-memory interface (address register output, data out, write enable) and the shared memory.
- Sequences one access at a time, with round-robin fairness.
- A core stalls on its request until it receives a one-cycle ack; its read data is valid with that ack.

---
 rtl/data_mem_arbiter_if.sv | 32 +++
 rtl/data_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Purpose : bundles the per-core request side and the shared-memory side of
//           the data-memory arbiter into one connection.
// Ports   : req/we/addr/wdata (cores -> arbiter), ack/rdata (arbiter -> cores),
//           mem_addr/mem_wdata/mem_wrEn (arbiter -> memory), mem_rdata (memory -> arbiter),
//           busy (arbiter status). slave = arbiter view, master = cores + memory view.
interface data_mem_arbiter_if #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12
);
  logic [NUM_CORES-1:0]            req;
  logic [NUM_CORES-1:0]            we;
  logic [NUM_CORES*ADDR_WIDTH-1:0] addr;
  logic [NUM_CORES*DATA_WIDTH-1:0] wdata;
  logic [NUM_CORES-1:0]            ack;
  logic [DATA_WIDTH-1:0]           rdata;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic                            mem_wrEn;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            busy;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output ack, rdata, mem_addr, mem_wdata, mem_wrEn, busy
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  ack, rdata, mem_addr, mem_wdata, mem_wrEn, busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Purpose : shares one single-port synchronous data memory between NUM_CORES
//           cores, one access at a time, round-robin (or fixed priority when
//           ARB_FIXED_PRIO_EN is defined: lowest index wins).
// Ports   : clk, rst (sync, active-high), bus (data_mem_arbiter_if.slave).
//           Latency req->ack: write 3 cycles, read RD_LATENCY+2 cycles; a core
//           stalls with req high until its one-cycle ack; all outputs registered.
module data_mem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, DONE} state_t;

  state_t                  r_state,     w_state_nxt;
  logic [IDX_W-1:0]        r_win,       w_win_nxt;
  logic [CNT_W-1:0]        r_cnt,       w_cnt_nxt;
  logic [NUM_CORES-1:0]    r_ack,       w_ack_nxt;
  logic [DATA_WIDTH-1:0]   r_rdata,     w_rdata_nxt;
  logic [ADDR_WIDTH-1:0]   r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic                    r_mem_wrEn,  w_mem_wrEn_nxt;
  logic                    r_busy,      w_busy_nxt;

  logic [NUM_CORES-1:0]    w_elig;
  logic                    w_any;
  logic [IDX_W-1:0]        w_pick;

  // The core being acked this cycle may still hold req (it only drops it
  // next cycle), so it is excluded from this arbitration round.
  assign w_elig = bus.req & ~r_ack;
  assign w_any  = |w_elig;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    w_pick = '0;
    // Descending scan: the last hit, i.e. the lowest index, wins.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_elig[IDX_W'(i)]) w_pick = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] r_last, w_last_nxt;

  always_comb begin
    int v_idx;
    v_idx  = 0;
    w_pick = '0;
    // Scan offsets far-to-near so the nearest requester after r_last wins.
    for (int k = NUM_CORES; k >= 1; k--) begin
      v_idx = int'(r_last) + k;
      if (v_idx >= NUM_CORES) v_idx = v_idx - NUM_CORES;
      if (w_elig[IDX_W'(v_idx)]) w_pick = IDX_W'(v_idx);
    end
  end

  always_comb begin
    w_last_nxt = r_last;
    if (r_state == IDLE && w_any) w_last_nxt = w_pick;
  end

  always_ff @(posedge clk) begin
    if (rst) r_last <= IDX_W'(NUM_CORES - 1);
    else     r_last <= w_last_nxt;
  end
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_win_nxt       = r_win;
    w_cnt_nxt       = r_cnt;
    w_ack_nxt       = '0;
    w_rdata_nxt     = r_rdata;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_wrEn_nxt  = 1'b0;
    w_busy_nxt      = r_busy;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_win_nxt       = w_pick;
          w_mem_addr_nxt  = bus.addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
          w_mem_wdata_nxt = bus.wdata[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
          w_busy_nxt      = 1'b1;
          w_cnt_nxt       = '0;
          if (bus.we[w_pick]) begin
            w_state_nxt    = WRITE;
            // Registered, so the strobe is high exactly during WRITE.
            w_mem_wrEn_nxt = 1'b1;
          end else begin
            w_state_nxt    = READ_WAIT;
          end
        end
      end
      WRITE: begin
        w_state_nxt = DONE;
      end
      READ_WAIT: begin
        if (r_cnt == CNT_W'(RD_LATENCY - 1)) begin
          w_rdata_nxt = bus.mem_rdata;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_ack_nxt[r_win] = 1'b1;
        w_busy_nxt       = 1'b0;
        w_state_nxt      = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_win       <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wrEn  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_win       <= w_win_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ack       <= w_ack_nxt;
      r_rdata     <= w_rdata_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_wrEn  <= w_mem_wrEn_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.ack       = r_ack;
  assign bus.rdata     = r_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wrEn  = r_mem_wrEn;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  localparam int NC = 4;
  localparam int DW = 12;
  localparam int AW = 12;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.NUM_CORES(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  data_mem_arbiter #(.NUM_CORES(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: one registered read stage, so data for an address presented
  // in cycle n is on mem_rdata in cycle n+1 (RD_LATENCY = 2 as counted by the DUT).
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we)             mem[bd_addr] <= bd_data;
    else if (bus.mem_wrEn) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic clear_inputs();
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.ack, bus.rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wrEn, bus.busy} !== 42'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0",
               {bus.ack, bus.rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wrEn, bus.busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [5:0] e;
    @(posedge clk); #1;
    bus.req[2] = 1'b1; bus.we[2] = 1'b1;
    bus.addr[2*AW +: AW] = 12'h05A; bus.wdata[2*DW +: DW] = 12'h3C7;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 4) bus.req[2] = 1'b0;
      @(negedge clk);
      e = {1'(c == 1), 1'(c == 1 || c == 2), (c == 3) ? 4'b0100 : 4'b0000};
      n_chk++;
      if ({bus.mem_wrEn, bus.busy, bus.ack} !== e) begin
        n_fail++;
        $display("FAIL write_c%0d {wrEn,busy,ack}: got %b expected %b", c, {bus.mem_wrEn, bus.busy, bus.ack}, e);
      end
      if (c == 1) begin
        n_chk++;
        if ({bus.mem_addr, bus.mem_wdata} !== {12'h05A, 12'h3C7}) begin
          n_fail++;
          $display("FAIL write_bus {addr,wdata}: got %h expected 05a3c7", {bus.mem_addr, bus.mem_wdata});
        end
      end
    end
  endtask

  task automatic test_read();
    logic [5:0] e;
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = 12'h010; bd_data = 12'h123;
    @(posedge clk); #1;
    bd_we = 1'b0;
    bus.req[1] = 1'b1; bus.we[1] = 1'b0; bus.addr[1*AW +: AW] = 12'h010;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 5) bus.req[1] = 1'b0;
      @(negedge clk);
      e = {1'b0, 1'(c >= 1 && c <= 3), (c == 4) ? 4'b0010 : 4'b0000};
      n_chk++;
      if ({bus.mem_wrEn, bus.busy, bus.ack} !== e) begin
        n_fail++;
        $display("FAIL read_c%0d {wrEn,busy,ack}: got %b expected %b", c, {bus.mem_wrEn, bus.busy, bus.ack}, e);
      end
      if (c == 1) begin
        n_chk++;
        if ({bus.mem_addr, bus.rdata} !== {12'h010, 12'h000}) begin
          n_fail++;
          $display("FAIL read_start {addr,rdata}: got %h expected 010000", {bus.mem_addr, bus.rdata});
        end
      end
      if (c == 4) begin
        n_chk++;
        if (bus.rdata !== 12'h123) begin
          n_fail++;
          $display("FAIL read_data: got %h expected 123", bus.rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.req[2] = 1'b1; bus.we[2] = 1'b0; bus.addr[2*AW +: AW] = 12'h010;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req[2] = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.busy, bus.mem_wrEn, bus.rdata} !== {1'b1, 1'b0, 12'h123}) begin
      n_fail++;
      $display("FAIL rstmid_pre {busy,wrEn,rdata}: got %h expected 2123", {bus.busy, bus.mem_wrEn, bus.rdata});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.busy, bus.ack, bus.mem_wrEn, bus.rdata} !== 18'h0) begin
      n_fail++;
      $display("FAIL rstmid_post {busy,ack,wrEn,rdata}: got %h expected 0", {bus.busy, bus.ack, bus.mem_wrEn, bus.rdata});
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.busy, bus.ack} !== 5'b0) begin
        n_fail++;
        $display("FAIL rstmid_noack_c%0d {busy,ack}: got %b expected 00000", c, {bus.busy, bus.ack});
      end
    end
  endtask

  task automatic test_simul_rw();
    logic [4:0] e;
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = 12'h020; bd_data = 12'h555;
    @(posedge clk); #1;
    bd_we = 1'b0;
    bus.req[0] = 1'b1; bus.we[0] = 1'b1; bus.addr[0 +: AW] = 12'h020; bus.wdata[0 +: DW] = 12'h7FF;
    bus.req[3] = 1'b1; bus.we[3] = 1'b0; bus.addr[3*AW +: AW] = 12'h020;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 4) bus.req[0] = 1'b0;
      if (c == 8) bus.req[3] = 1'b0;
      @(negedge clk);
      e = {1'(c == 1 || c == 2 || c == 4 || c == 5 || c == 6),
           (c == 3) ? 4'b0001 : ((c == 7) ? 4'b1000 : 4'b0000)};
      n_chk++;
      if ({bus.busy, bus.ack} !== e) begin
        n_fail++;
        $display("FAIL simul_c%0d {busy,ack}: got %b expected %b", c, {bus.busy, bus.ack}, e);
      end
      if (c == 7) begin
        n_chk++;
        if (bus.rdata !== 12'h7FF) begin
          n_fail++;
          $display("FAIL simul_rdata: got %h expected 7ff", bus.rdata);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int pend[NC];
    int exp_ord[6];
    int n_got;
`ifdef ARB_FIXED_PRIO_EN
    exp_ord = '{0, 1, 0, 1, 0, 1};
`else
    exp_ord = '{0, 1, 2, 3, 0, 1};
`endif
    n_got = 0;
    @(posedge clk); #1;
    for (int i = 0; i < NC; i++) begin
      pend[i] = 0;
      bus.req[i] = 1'b1; bus.we[i] = 1'b1;
      bus.addr[i*AW +: AW] = 12'h100 + 12'(i);
      bus.wdata[i*DW +: DW] = 12'hA00 + 12'(i);
    end
    for (int cyc = 0; cyc < 60 && n_got < 6; cyc++) begin
      @(negedge clk);
      n_chk++;
      if ($countones(bus.ack) > 1) begin
        n_fail++;
        $display("FAIL rr_onehot: got ack %b expected at most one bit", bus.ack);
      end
      for (int i = 0; i < NC; i++) begin
        if (bus.ack[i]) begin
          n_chk++;
          if (n_got >= 6 || i != exp_ord[n_got]) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got core %0d expected core %0d", n_got, i, exp_ord[n_got % 6]);
          end
          n_got++;
          pend[i] = 2;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < NC; i++) begin
        if (pend[i] == 2) begin
          bus.req[i] = 1'b0; pend[i] = 1;
        end else if (pend[i] == 1) begin
          bus.req[i] = 1'b1; pend[i] = 0;
        end
      end
    end
    n_chk++;
    if (n_got != 6) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d grants expected 6", n_got);
    end
    clear_inputs();
    repeat (12) @(posedge clk);
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.mem_wrEn, bus.ack, bus.busy} !== 6'b0) begin
        n_fail++;
        $display("FAIL idle_c%0d {wrEn,ack,busy}: got %b expected 000000", c, {bus.mem_wrEn, bus.ack, bus.busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_reset_mid();
    test_simul_rw();
    test_round_robin();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
